// File: rtl/gpu_mem_pkg.sv
// ============================================================================
// Module : gpu_mem_pkg
// Brief  : Shared types and constants for the GPU memory channel arbiters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gpu_mem_pkg;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_WAIT   = 3'd1,
        WRITE_WAIT  = 3'd2,
        READ_RELAY  = 3'd3,
        WRITE_RELAY = 3'd4
    } chan_state_t;

    // Width of a consumer index; a single consumer still needs one bit.
    function automatic int consumer_id_bits(input int num_consumers);
        return (num_consumers > 1) ? $clog2(num_consumers) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_channel_arbiter.sv
// ============================================================================
// Module : mem_channel_arbiter
// Brief  : Maps NUM_CONSUMERS valid/ready request ports onto NUM_CHANNELS
//          one-pulse-ready memory channels. Define MEM_ARB_ROUND_ROBIN_EN for
//          per-channel round-robin search; otherwise fixed lowest-index wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_channel_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS],
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,

    output logic [NUM_CHANNELS-1:0]  mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address       [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data          [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0]  mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address      [NUM_CHANNELS],
    output logic [DATA_BITS-1:0]     mem_write_data         [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_write_ready
);

    localparam int ID_BITS = consumer_id_bits(NUM_CONSUMERS);

    chan_state_t                state   [NUM_CHANNELS];
    logic [ID_BITS-1:0]         owner   [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]   claimed;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [ID_BITS-1:0]         last_grant [NUM_CHANNELS];
`endif

    logic [NUM_CONSUMERS-1:0]   write_req;
    logic [NUM_CHANNELS-1:0]    grant_valid;
    logic [NUM_CHANNELS-1:0]    grant_read;
    logic [ID_BITS-1:0]         grant_id [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0]    wr_valid_q;
    logic [ADDR_BITS-1:0]       wr_addr_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0]       wr_data_q [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]   wr_ready_q;

    assign write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

    // Channels are walked in ascending order; 'taken' accumulates the claims
    // of lower channels so no consumer is granted twice in one cycle.
    always_comb begin : arbitrate
        logic [NUM_CONSUMERS-1:0] taken;
        int start;
        int idx;
        taken       = claimed;
        grant_valid = '0;
        grant_read  = '0;
        start       = 0;
        idx         = 0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            grant_id[ch] = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            start = (int'(last_grant[ch]) + 1) % NUM_CONSUMERS;
`else
            start = 0;
`endif
            if (state[ch] == IDLE) begin
                for (int i = 0; i < NUM_CONSUMERS; i++) begin
                    idx = (start + i) % NUM_CONSUMERS;
                    if (!grant_valid[ch] && !taken[idx] &&
                        (consumer_read_valid[idx] || write_req[idx])) begin
                        grant_valid[ch] = 1'b1;
                        grant_id[ch]    = ID_BITS'(idx);
                        grant_read[ch]  = consumer_read_valid[idx];
                    end
                end
                if (grant_valid[ch]) begin
                    taken[grant_id[ch]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            claimed             <= '0;
            consumer_read_ready <= '0;
            wr_ready_q          <= '0;
            mem_read_valid      <= '0;
            wr_valid_q          <= '0;
            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                consumer_read_data[c] <= '0;
            end
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state[ch]            <= IDLE;
                owner[ch]            <= '0;
                mem_read_address[ch] <= '0;
                wr_addr_q[ch]        <= '0;
                wr_data_q[ch]        <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_grant[ch]       <= '0;
`endif
            end
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state[ch])
                    IDLE: begin
                        if (grant_valid[ch]) begin
                            owner[ch]              <= grant_id[ch];
                            claimed[grant_id[ch]]  <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                            last_grant[ch]         <= grant_id[ch];
`endif
                            if (grant_read[ch]) begin
                                mem_read_valid[ch]   <= 1'b1;
                                mem_read_address[ch] <= consumer_read_address[grant_id[ch]];
                                state[ch]            <= READ_WAIT;
                            end else begin
                                wr_valid_q[ch] <= 1'b1;
                                wr_addr_q[ch]  <= consumer_write_address[grant_id[ch]];
                                wr_data_q[ch]  <= consumer_write_data[grant_id[ch]];
                                state[ch]      <= WRITE_WAIT;
                            end
                        end
                    end
                    // Valid must fall on the ack edge or memory acks again.
                    READ_WAIT: begin
                        if (mem_read_ready[ch]) begin
                            consumer_read_data[owner[ch]]  <= mem_read_data[ch];
                            consumer_read_ready[owner[ch]] <= 1'b1;
                            mem_read_valid[ch]             <= 1'b0;
                            state[ch]                      <= READ_RELAY;
                        end
                    end
                    WRITE_WAIT: begin
                        if (mem_write_ready[ch]) begin
                            wr_ready_q[owner[ch]] <= 1'b1;
                            wr_valid_q[ch]        <= 1'b0;
                            state[ch]             <= WRITE_RELAY;
                        end
                    end
                    READ_RELAY: begin
                        if (!consumer_read_valid[owner[ch]]) begin
                            consumer_read_ready[owner[ch]] <= 1'b0;
                            claimed[owner[ch]]             <= 1'b0;
                            state[ch]                      <= IDLE;
                        end
                    end
                    WRITE_RELAY: begin
                        if (!consumer_write_valid[owner[ch]]) begin
                            wr_ready_q[owner[ch]] <= 1'b0;
                            claimed[owner[ch]]    <= 1'b0;
                            state[ch]             <= IDLE;
                        end
                    end
                    default: state[ch] <= IDLE;
                endcase
            end
        end
    end

    // Read-only instances expose constant-zero write outputs.
    always_comb begin : write_outputs
        mem_write_valid      = (WRITE_ENABLE != 0) ? wr_valid_q : '0;
        consumer_write_ready = (WRITE_ENABLE != 0) ? wr_ready_q : '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            mem_write_address[ch] = (WRITE_ENABLE != 0) ? wr_addr_q[ch] : '0;
            mem_write_data[ch]    = (WRITE_ENABLE != 0) ? wr_data_q[ch] : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_channel_arbiter.sv
// ============================================================================
// Module : tb_mem_channel_arbiter
// Brief  : Scoreboard bench: 8x4 read/write arbiter plus an 8x1 read-only one.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_channel_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8 consumers, 4 channels, read/write
    logic [7:0] rv, rr, wv, wr;
    logic [7:0] ra [8];
    logic [7:0] rd [8];
    logic [7:0] wa [8];
    logic [7:0] wd [8];
    logic [3:0] mrv, mrr, mwv, mwr;
    logic [7:0] mra [4];
    logic [7:0] mrd [4];
    logic [7:0] mwa [4];
    logic [7:0] mwd [4];

    // 8 consumers, 1 channel, read-only
    logic [7:0] c1_rv, c1_rr, c1_wv, c1_wr;
    logic [7:0] c1_ra [8];
    logic [7:0] c1_rd [8];
    logic [7:0] c1_wa [8];
    logic [7:0] c1_wd [8];
    logic [0:0] m1_rv, m1_rr, m1_wv, m1_wr;
    logic [7:0] m1_ra [1];
    logic [7:0] m1_rd [1];
    logic [7:0] m1_wa [1];
    logic [7:0] m1_wd [1];

    mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8),
                          .NUM_CHANNELS(4), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(rst),
        .consumer_read_valid(rv), .consumer_read_address(ra),
        .consumer_read_ready(rr), .consumer_read_data(rd),
        .consumer_write_valid(wv), .consumer_write_address(wa),
        .consumer_write_data(wd), .consumer_write_ready(wr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr)
    );

    mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8),
                          .NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut1 (
        .clk(clk), .reset(rst),
        .consumer_read_valid(c1_rv), .consumer_read_address(c1_ra),
        .consumer_read_ready(c1_rr), .consumer_read_data(c1_rd),
        .consumer_write_valid(c1_wv), .consumer_write_address(c1_wa),
        .consumer_write_data(c1_wd), .consumer_write_ready(c1_wr),
        .mem_read_valid(m1_rv), .mem_read_address(m1_ra),
        .mem_read_ready(m1_rr), .mem_read_data(m1_rd),
        .mem_write_valid(m1_wv), .mem_write_address(m1_wa),
        .mem_write_data(m1_wd), .mem_write_ready(m1_wr)
    );

    int total = 0;
    int bad   = 0;
    int rd_acks = 0;
    int wr_acks = 0;
    logic hold_wr = 1'b0;
    logic [7:0] want1 = '0;

    typedef struct packed { logic [2:0] id; logic [7:0] data; } rd_exp_t;
    typedef struct packed { logic [2:0] id; logic [7:0] addr; logic [7:0] data; } wr_exp_t;
    rd_exp_t    rd_q [$];
    wr_exp_t    wr_q [$];
    logic [7:0] grant_q [$];
    logic [7:0] mem [256];

    function automatic logic [7:0] mem_init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'h5A : (a ^ 8'hA5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One-cycle memories: ack pulses one cycle after valid is seen.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mrr <= '0;
            mwr <= '0;
            m1_rr <= '0;
            m1_wr <= '0;
            for (int a = 0; a < 256; a++) mem[a] <= mem_init_val(8'(a));
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                if (mrr[ch]) mrr[ch] <= 1'b0;
                else if (mrv[ch]) begin
                    mrr[ch] <= 1'b1;
                    mrd[ch] <= mem[mra[ch]];
                end
                if (mwr[ch]) mwr[ch] <= 1'b0;
                else if (mwv[ch]) begin
                    mwr[ch] <= 1'b1;
                    mem[mwa[ch]] <= mwd[ch];
                end
            end
            if (m1_rr[0]) m1_rr[0] <= 1'b0;
            else if (m1_rv[0]) begin
                m1_rr[0] <= 1'b1;
                m1_rd[0] <= mem[m1_ra[0]];
            end
            if (m1_wr[0]) m1_wr[0] <= 1'b0;
            else if (m1_wv[0]) m1_wr[0] <= 1'b1;
        end
    end

    // Consumer behaviour: drop valid once ready is seen; dut1 consumers re-request.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (rv[i] && rr[i]) rv[i] = 1'b0;
                if (!hold_wr && wv[i] && wr[i]) wv[i] = 1'b0;
                if (c1_rv[i] && c1_rr[i]) c1_rv[i] = 1'b0;
                else if (!c1_rv[i] && want1[i]) c1_rv[i] = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [7:0] prev_rr = '0;
        logic [7:0] prev_wr = '0;
        logic       prev_m1 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rd_acks += $countones(mrr);
                wr_acks += $countones(mwr);
                for (int i = 0; i < 8; i++) begin
                    if (rr[i] && !prev_rr[i]) begin
                        int k;
                        k = -1;
                        for (int j = 0; j < rd_q.size(); j++)
                            if (k < 0 && rd_q[j].id == 3'(i)) k = j;
                        if (k < 0) check("rd_unexpected", 32'(i), 32'hFF);
                        else begin
                            check("rd_data", rd[i], rd_q[k].data);
                            rd_q.delete(k);
                        end
                    end
                    if (wr[i] && !prev_wr[i]) begin
                        int k;
                        k = -1;
                        for (int j = 0; j < wr_q.size(); j++)
                            if (k < 0 && wr_q[j].id == 3'(i)) k = j;
                        if (k < 0) check("wr_unexpected", 32'(i), 32'hFF);
                        else begin
                            check("wr_mem", mem[wr_q[k].addr], wr_q[k].data);
                            wr_q.delete(k);
                        end
                    end
                end
                for (int a = 0; a < 4; a++)
                    for (int b = a + 1; b < 4; b++)
                        if (mrv[a] && mrv[b])
                            check("chan_overlap", 32'(mra[a] != mra[b]), 32'd1);
                if (m1_rv[0] && !prev_m1 && grant_q.size() > 0)
                    check("rr_grant", m1_ra[0], grant_q.pop_front());
            end
            prev_rr = rr;
            prev_wr = wr;
            prev_m1 = m1_rv[0];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rv = '0; wv = '0; c1_rv = '0; c1_wv = '0; want1 = '0;
        hold_wr = 1'b0;
        rd_q.delete(); wr_q.delete(); grant_q.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_done(input string name, input int bound);
        int c;
        c = 0;
        while (((rv | wv | rr | wr) != '0) && c < bound) begin
            tick(1);
            c++;
        end
        check(name, 32'(c < bound), 32'd1);
    endtask

    task automatic issue_read(input int id, input logic [7:0] addr);
        ra[id] = addr;
        rd_q.push_back('{id: 3'(id), data: mem_init_val(addr)});
        rv[id] = 1'b1;
    endtask

    initial begin
        int base;
        int c;
        rst = 1'b1;
        rv = '0; wv = '0; c1_rv = '0; c1_wv = '0;
        for (int i = 0; i < 8; i++) begin
            ra[i] = '0; wa[i] = '0; wd[i] = '0;
            c1_ra[i] = '0; c1_wa[i] = 8'(8'h80 + i); c1_wd[i] = 8'(8'h90 + i);
        end
        do_reset();
        check("reset_outputs", {mrv, mwv, rr, wr}, 24'h0);

        // Single read: consumer 2, address 0x10
        issue_read(2, 8'h10);
        base = rd_acks;
        tick(1);
        check("rd1_mem_valid", mrv, 4'b0001);
        check("rd1_mem_addr", mra[0], 8'h10);
        tick(1);
        check("rd1_not_early", rr[2], 1'b0);
        tick(1);
        check("rd1_ready", rr[2], 1'b1);
        check("rd1_data", rd[2], 8'h5A);
        check("rd1_valid_cleared", mrv, 4'b0000);
        tick(1);
        check("rd1_ready_drop", rr[2], 1'b0);
        tick(3);
        check("rd1_single_req", rd_acks - base, 1);

        // Single write with ready held until valid falls
        hold_wr = 1'b1;
        wa[5] = 8'h20; wd[5] = 8'hC3;
        wr_q.push_back('{id: 3'd5, addr: 8'h20, data: 8'hC3});
        wv[5] = 1'b1;
        base = wr_acks;
        tick(1);
        check("wr_mem_valid", mwv, 4'b0001);
        check("wr_mem_addr", mwa[0], 8'h20);
        check("wr_mem_data", mwd[0], 8'hC3);
        tick(2);
        check("wr_ready", wr[5], 1'b1);
        tick(3);
        check("wr_ready_held", wr[5], 1'b1);
        wv[5] = 1'b0;
        tick(1);
        check("wr_ready_drop", wr[5], 1'b0);
        check("wr_mem_final", mem[8'h20], 8'hC3);
        check("wr_single_req", wr_acks - base, 1);
        hold_wr = 1'b0;

        // Contention: 8 readers on 4 channels
        do_reset();
        base = rd_acks;
        for (int i = 0; i < 8; i++) issue_read(i, 8'(i));
        tick(1);
        check("cont_all_busy", mrv, 4'hF);
        for (int ch = 0; ch < 4; ch++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // pointers reset to 0, so the search begins at consumer 1
            check("cont_first_addr", mra[ch], 8'(ch + 1));
`else
            check("cont_first_addr", mra[ch], 8'(ch));
`endif
        end
        wait_done("cont_drain", 60);
        check("cont_acks", rd_acks - base, 8);
        check("cont_sb_empty", rd_q.size(), 0);

        // Ordering: two consumers, four channels
        do_reset();
        issue_read(0, 8'h30);
        issue_read(1, 8'h31);
        tick(1);
        check("ord_valids", mrv, 4'b0011);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("ord_ch0", mra[0], 8'h31);
        check("ord_ch1", mra[1], 8'h30);
`else
        check("ord_ch0", mra[0], 8'h30);
        check("ord_ch1", mra[1], 8'h31);
`endif
        wait_done("ord_drain", 30);

        // Single-channel re-arbitration on the read-only instance
        do_reset();
        c1_ra[0] = 8'h40; c1_ra[1] = 8'h41;
        c1_wv = 8'hFF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant_q = '{8'h41, 8'h40, 8'h41, 8'h40};
`else
        grant_q = '{8'h40, 8'h40, 8'h40, 8'h40};
`endif
        want1 = 8'b0000_0011;
        c = 0;
        while (grant_q.size() > 0 && c < 80) begin
            tick(1);
            c++;
        end
        check("rr_grants_seen", 32'(c < 80), 32'd1);
        check("ro_wr_valid", m1_wv, 1'b0);
        check("ro_wr_ready", c1_wr, 8'h00);
        check("ro_wr_addr", m1_wa[0], 8'h00);
        want1 = '0;
        c = 0;
        while ((c1_rv | c1_rr) != '0 && c < 30) begin
            tick(1);
            c++;
        end
        check("rr_drain", 32'(c < 30), 32'd1);
        c1_wv = '0;

        // Reset while a read is waiting on memory
        do_reset();
        issue_read(3, 8'h33);
        tick(1);
        check("rst_in_wait", mrv[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_clear", {mrv, mwv, rr, wr}, 24'h0);
        rv = '0;
        rd_q.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
        base = rd_acks;
        issue_read(3, 8'h33);
        wait_done("rst_fresh_read", 20);
        check("rst_fresh_acks", rd_acks - base, 1);
        check("rst_sb_empty", rd_q.size(), 0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
